// File: rtl/one_port_mem_req_ctrl.sv
// one_port_mem_req_ctrl: valid/ready front-end for a single-port memory with 1-cycle read latency.
// Read credits guarantee every issued read has a buffer slot, so backpressure never drops data.
module one_port_mem_req_ctrl #(
  parameter int addresses = 32,
  parameter int width = 8,
  parameter int rspDepth = 2,
  localparam int addressWidth = $clog2(addresses),
  localparam int outW = $clog2(rspDepth + 1)
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic                    reqValid,
  output logic                    reqReady,
  input  logic                    reqWrite,
  input  logic [addressWidth-1:0] reqAddress,
  input  logic [width-1:0]        reqWriteData,
  output logic                    rspValid,
  input  logic                    rspReady,
  output logic [width-1:0]        rspData,
  output logic                    rspErr,
  output logic                    memReadEnable,
  output logic                    memWriteEnable,
  output logic [addressWidth-1:0] memAddress,
  output logic [width-1:0]        memWriteData,
  input  logic [width-1:0]        memReadData,
  output logic [outW-1:0]         outstanding
);
  localparam int ptrW = $clog2(rspDepth);
  localparam logic [addressWidth:0] addrLimit = (addressWidth + 1)'(addresses);
  localparam logic [ptrW-1:0] lastPtr = ptrW'(rspDepth - 1);
  logic [ptrW-1:0] head, tail;
  logic [outW-1:0] count;
  logic inFlight, inFlightErr;
  logic [width-1:0] bufData [rspDepth];
  logic [rspDepth-1:0] bufErr;
  logic inRange, accept, readAcc, bufEmpty, push, pop, popBuf;
  logic [width-1:0] bypassData;
  assign outstanding = count + outW'(inFlight);
  assign inRange = {1'b0, reqAddress} < addrLimit;
  assign reqReady = reqWrite || (outstanding < outW'(rspDepth));
  assign accept = reqValid && reqReady;
  assign readAcc = accept && !reqWrite;
  assign memWriteEnable = accept && reqWrite && inRange;
  assign memReadEnable = readAcc && inRange;
  assign memAddress = reqAddress;
  assign memWriteData = reqWriteData;
  assign bufEmpty = count == '0;
  assign bypassData = inFlightErr ? '0 : memReadData;
  assign rspValid = !bufEmpty || inFlight;
  assign rspData = bufEmpty ? bypassData : bufData[head];
  assign rspErr = bufEmpty ? inFlightErr : bufErr[head];
  assign pop = rspValid && rspReady;
  assign popBuf = pop && !bufEmpty;
  // The in-flight word bypasses the buffer only when nothing is queued ahead of it and it is taken now.
  assign push = inFlight && !(bufEmpty && rspReady);
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      inFlight <= 1'b0;
      inFlightErr <= 1'b0;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      inFlight <= readAcc;
      inFlightErr <= readAcc && !inRange;
      if (push) tail <= (tail == lastPtr) ? '0 : tail + 1'b1;
      if (popBuf) head <= (head == lastPtr) ? '0 : head + 1'b1;
      count <= count + outW'(push) - outW'(popBuf);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      bufData[tail] <= bypassData;
      bufErr[tail] <= inFlightErr;
    end
  end
endmodule

// File: tb/tb_one_port_mem_req_ctrl.sv
// tb_one_port_mem_req_ctrl: scoreboard bench with a behavioural 1-cycle single-port memory.
module tb_one_port_mem_req_ctrl;
  localparam int addresses = 24;
  logic clk = 0, rstN = 0;
  logic reqValid = 0, reqReady, reqWrite = 0;
  logic [4:0] reqAddress = 0;
  logic [7:0] reqWriteData = 0;
  logic rspValid, rspReady = 0, rspErr;
  logic [7:0] rspData;
  logic memReadEnable, memWriteEnable;
  logic [4:0] memAddress;
  logic [7:0] memWriteData, memReadData;
  logic [1:0] outstanding;
  logic [7:0] memArr [32];
  logic [7:0] sbMem [32];
  logic [8:0] sbQ [$];
  logic [8:0] exp;
  logic lastRead = 0, acc, inR;
  int errors = 0, checks = 0, accCount = 0, cyc = 0, c0, a0, waits;

  one_port_mem_req_ctrl #(.addresses(addresses), .width(8), .rspDepth(2)) dut (
    .clk(clk), .rstN(rstN), .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqAddress(reqAddress), .reqWriteData(reqWriteData), .rspValid(rspValid), .rspReady(rspReady),
    .rspData(rspData), .rspErr(rspErr), .memReadEnable(memReadEnable), .memWriteEnable(memWriteEnable),
    .memAddress(memAddress), .memWriteData(memWriteData), .memReadData(memReadData),
    .outstanding(outstanding));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    if (memWriteEnable) memArr[memAddress] <= memWriteData;
    if (memReadEnable) memReadData <= memArr[memAddress];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rstN) begin
      check("outMax", 32'(outstanding <= 2'd2), 1);
      if (rspValid && rspReady) begin
        if (sbQ.size() == 0) check("rspExtra", 1, 0);
        else begin
          exp = sbQ.pop_front();
          check("rspData", rspData, exp[7:0]);
          check("rspErr", rspErr, exp[8]);
        end
      end
      if (lastRead) check("rspLatency", rspValid, 1);
      acc = reqValid && reqReady;
      inR = reqAddress < 5'(addresses);
      check("memWe", memWriteEnable, acc && reqWrite && inR);
      check("memRe", memReadEnable, acc && !reqWrite && inR);
      lastRead = acc && !reqWrite;
      if (acc) begin
        accCount++;
        if (reqWrite) begin
          if (inR) sbMem[reqAddress] = reqWriteData;
        end else sbQ.push_back(inR ? {1'b0, sbMem[reqAddress]} : 9'h100);
      end
    end else lastRead = 0;
  end

  task automatic issue(input logic w, input logic [4:0] a, input logic [7:0] d);
    reqValid = 1; reqWrite = w; reqAddress = a; reqWriteData = d;
    waits = 0;
    do begin @(negedge clk); waits++; end while (!reqReady && waits < 50);
    if (!reqReady) check("reqTimeout", 0, 1);
    @(posedge clk); #1;
    reqValid = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      memArr[i] = 8'(i) ^ 8'h3C;
      sbMem[i] = 8'(i) ^ 8'h3C;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rstOutstanding", outstanding, 0);
    check("rstRspValid", rspValid, 0);
    check("rstRspErr", rspErr, 0);
    check("rstReqReady", reqReady, 1);
    rstN = 1;
    @(posedge clk); #1;
    rspReady = 1;
    issue(1, 5, 8'hA5);
    issue(0, 5, 0);
    repeat (2) @(posedge clk); #1;
    c0 = cyc;
    for (int i = 0; i < 8; i++) issue(0, 5'(i), 0);
    check("b2bCycles", cyc - c0, 8);
    repeat (2) @(posedge clk); #1;
    rspReady = 0;
    a0 = accCount;
    reqValid = 1; reqWrite = 0; reqAddress = 6;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("bpAccepted", accCount - a0, 2);
    check("bpReadyLow", reqReady, 0);
    check("bpOutstanding", outstanding, 2);
    @(posedge clk); #1;
    rspReady = 1;
    waits = 0;
    do begin @(negedge clk); waits++; end while (!reqReady && waits < 10);
    check("bpReadyBack", reqReady, 1);
    @(posedge clk); #1;
    reqValid = 0;
    repeat (3) @(posedge clk); #1;
    issue(0, 30, 0);
    issue(1, 30, 8'h77);
    issue(0, 23, 0);
    repeat (2) @(posedge clk); #1;
    rspReady = 0;
    issue(0, 3, 0);
    issue(1, 3, 8'hFF);
    rspReady = 1;
    issue(0, 3, 0);
    repeat (3) @(posedge clk); #1;
    check("sbDrained", sbQ.size(), 0);
    rspReady = 0;
    issue(0, 1, 0);
    issue(0, 2, 0);
    #2 rstN = 0;
    #1;
    check("midRstOutstanding", outstanding, 0);
    check("midRstRspValid", rspValid, 0);
    sbQ.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1;
    rspReady = 1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("postRstQuiet", rspValid, 0);
    check("sbEmpty", sbQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
